fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, address fetched first after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: PCAddress  output  16  address driven to InstructionMemory (combinational read).
REQ-005 SHALL have port: Instruction  input  16  word returned by InstructionMemory for PCAddress, same cycle.
REQ-006 SHALL have port: instr_out  output  16  registered instruction for decode.
REQ-007 SHALL have port: instr_pc  output  16  address instr_out was fetched from.
REQ-008 SHALL have port: instr_valid  output  1  instr_out/instr_pc valid.
REQ-009 SHALL have port: instr_ready  input  1  decode accepts; transfer when instr_valid && instr_ready.
REQ-010 SHALL have port: redirect_valid  input  1  branch/jump taken this cycle.
REQ-011 SHALL have port: redirect_target  input  16  new fetch address.
REQ-012 SHALL have port: halted  output  1  fetch stopped on HALT opcode.

Function
REQ-013 SHALL drive PCAddress directly from the internal pc register (no combinational path from inputs).
REQ-014 SHALL load when (!instr_valid || instr_ready) && state==RUN && !redirect_valid: instr_out<=Instruction, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_STEP.
REQ-015 SHALL, when instr_valid && !instr_ready, hold instr_out, instr_pc, instr_valid and pc unchanged.
REQ-016 SHALL clear instr_valid after a transfer when no load occurs in the same cycle.
REQ-017 SHALL give fetch latency of one cycle: word at PCAddress in cycle N appears on instr_out in cycle N+1.
REQ-018 SHALL sustain one instruction per cycle while instr_ready stays 1.
REQ-019 SHALL wrap pc modulo 2^16: 16'hFFFE + 2 -> 16'h0000, no flag.
REQ-020 SHALL, on redirect_valid, set pc<={redirect_target[15:1],1'b0}, set instr_valid<=0, set state<=RUN, regardless of instr_ready or state.
REQ-021 SHALL give redirect priority over load and hold; the flushed word is never presented.
REQ-022 SHALL use states RUN and HALTED; RUN->HALTED per REQ-030; HALTED->RUN only on redirect_valid or reset.
REQ-023 SHALL drive halted = (state==HALTED).

Reset
REQ-024 SHALL, while rst_n==0, force pc=RESET_PC, instr_out=16'h0000, instr_pc=16'h0000, instr_valid=0, state=RUN, halted=0.
REQ-025 SHALL take effect asynchronously on rst_n falling, mid-transfer or mid-halt included; in-flight instruction discarded.
REQ-026 SHALL make the first load on the first rising clk edge after rst_n rises.

Configuration
REQ-027 SHALL gate HALT detection with macro FETCH_HALT_EN.
REQ-028 SHALL, without FETCH_HALT_EN, stay in RUN permanently and tie halted to 0; HALT_OPCODE treated as ordinary instruction.
REQ-029 SHALL, with FETCH_HALT_EN, apply REQ-030.
REQ-030 SHALL, when a load captures Instruction==HALT_OPCODE, present it normally (instr_valid=1), advance pc, enter HALTED; no loads in HALTED; instr_valid drops after its transfer.

Structure
REQ-031 SHALL take HALT_OPCODE (16'hFFFF), PC_STEP (16'd2) and the fetch state enum (RUN, HALTED) from the shared CPU package.
REQ-032 SHALL be implemented flat; no sub-module is natural.

Verification
REQ-033 SHALL cover reset: RESET_PC=16'd10, ready=1 -> PCAddress 10,12,14...; instr_pc 10 appears one cycle after reset release with the memory word at 10.
REQ-034 SHALL cover backpressure: ready=0 for 3 cycles with valid=1 at instr_pc 14 -> instr_out, instr_pc=14, PCAddress=16 held; resume with 16 next.
REQ-035 SHALL cover redirect: redirect_valid=1, target=16'h0041 while valid && !ready -> next cycle valid=0, PCAddress=16'h0040; then instr_pc=16'h0040.
REQ-036 SHALL cover wrap: pc=16'hFFFE, ready=1 -> instr_pc FFFE then 0000, no stall.
REQ-037 SHALL cover halt (FETCH_HALT_EN): word 16'hFFFF at 20 -> presented with instr_pc 20, halted=1, no further valid; redirect to 30 -> halted=0, fetch resumes at 30; without macro fetch continues at 22.
REQ-038 SHALL cover async reset mid-stream: rst_n low between edges with valid=1 -> instr_valid=0, PCAddress=RESET_PC immediately.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch stage: HALT opcode, PC step,
// fetch FSM states and the decode-side instruction packet.
package fetch_unit_pkg;

  localparam logic [15:0] HALT_OPCODE = 16'hFFFF;
  localparam logic [15:0] PC_STEP     = 16'd2;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  // Instruction register contents handed to decode.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives PCAddress from the pc register, captures the
// combinational memory word into a one-deep instruction register with a
// valid/ready handshake, and accepts redirects from branch resolution.
// Optional macro FETCH_HALT_EN: stop fetching after presenting HALT_OPCODE.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] PCAddress,
  input  logic [15:0] Instruction,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic        halted
);

  fetch_state_e state, state_nxt;
  logic [15:0]  pc;
  fetch_pkt_t   ir;
  logic         ir_vld;
  logic         load;
  logic         is_halt;
  logic         unused_tgt_lsb;

  // Targets are halfword aligned; bit 0 is dropped.
  assign unused_tgt_lsb = redirect_target[0];

  // Register is free when empty or being drained this cycle; redirect wins.
  assign load = (!ir_vld || instr_ready) && (state == RUN) && !redirect_valid;

`ifdef FETCH_HALT_EN
  assign is_halt = (Instruction == HALT_OPCODE);
`else
  assign is_halt = 1'b0;
`endif

  assign PCAddress   = pc;
  assign instr_out   = ir.word;
  assign instr_pc    = ir.pc;
  assign instr_valid = ir_vld;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // FSM next state: halt after capturing HALT, resume only on redirect.
  always_comb begin
    state_nxt = state;
    if (redirect_valid)        state_nxt = RUN;
    else if (load && is_halt)  state_nxt = HALTED;
  end

  // FSM outputs.
  always_comb begin
`ifdef FETCH_HALT_EN
    halted = (state == HALTED);
`else
    halted = 1'b0;
`endif
  end

  // pc and instruction register: redirect flush, load, or drain after transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      ir     <= '0;
      ir_vld <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= {redirect_target[15:1], 1'b0};
      ir_vld <= 1'b0;
    end else if (load) begin
      ir.word <= Instruction;
      ir.pc   <= pc;
      ir_vld  <= 1'b1;
      pc      <= pc + PC_STEP;
    end else if (ir_vld && instr_ready) begin
      ir_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected (pc, word) packets are queued as
// stimulus is planned and compared on every decode handshake.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [15:0] RPC     = 16'd10;
  localparam logic [15:0] HALT_AT = 16'd20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] PCAddress, Instruction, instr_out, instr_pc, redirect_target;
  logic        instr_valid, instr_ready, redirect_valid, halted;

  int          nchk = 0;
  int          npass = 0;
  fetch_pkt_t  sb[$];
  fetch_pkt_t  mon_e;

  always #5 clk = ~clk;

  function automatic logic [15:0] memw(input logic [15:0] a);
    return (a == HALT_AT) ? 16'hFFFF : (a ^ 16'h3C3C);
  endfunction

  // Combinational instruction memory.
  always_comb Instruction = memw(PCAddress);

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .PCAddress(PCAddress), .Instruction(Instruction),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a);
    fetch_pkt_t p;
    p.pc   = a;
    p.word = memw(a);
    sb.push_back(p);
  endtask

  // Redirect while decode is stalled; the pending word must be discarded.
  task automatic redirect_to(input logic [15:0] t);
    instr_ready     = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = t;
    cyc();
    chk("redir_vld", instr_valid, 0);
    chk("redir_pc", PCAddress, {t[15:1], 1'b0});
    chk("redir_halted", halted, 0);
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
  endtask

  // n back-to-back loads from s; the last one stays presented, not consumed.
  task automatic run_stream(input logic [15:0] s, input int n);
    logic [15:0] a;
    a = s;
    for (int k = 0; k < n - 1; k++) begin
      push(a);
      a = a + 16'd2;
    end
    a = s;
    for (int k = 0; k < n; k++) begin
      cyc();
      chk("stream_pc", instr_pc, a);
      chk("stream_vld", instr_valid, 1);
      a = a + 16'd2;
    end
  endtask

  // Decode side: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("xfer_pc", instr_pc, mon_e.pc);
        chk("xfer_word", instr_out, mon_e.word);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    instr_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 16'h0000;
    rst_n           = 1'b0;
    repeat (2) cyc();
    chk("rst_pc", PCAddress, RPC);
    chk("rst_vld", instr_valid, 0);
    chk("rst_out", instr_out, 0);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_halted", halted, 0);

    // Release and stream from RESET_PC.
    rst_n = 1'b1;
    push(16'd10);
    push(16'd12);
    cyc();
    chk("first_ipc", instr_pc, 16'd10);
    chk("first_word", instr_out, memw(16'd10));
    chk("first_addr", PCAddress, 16'd12);
    cyc();
    cyc();
    chk("pre_bp_ipc", instr_pc, 16'd14);

    // Backpressure for three cycles.
    instr_ready = 1'b0;
    repeat (3) begin
      cyc();
      chk("hold_ipc", instr_pc, 16'd14);
      chk("hold_word", instr_out, memw(16'd14));
      chk("hold_vld", instr_valid, 1);
      chk("hold_addr", PCAddress, 16'd16);
    end
    push(16'd14);
    instr_ready = 1'b1;
    cyc();
    chk("resume_ipc", instr_pc, 16'd16);

    // Redirect with a stalled word pending (16 is flushed).
    redirect_to(16'h0041);
    run_stream(16'h0040, 3);

    // pc wrap.
    redirect_to(16'hFFFC);
    run_stream(16'hFFFC, 4);

    // HALT opcode at address 20.
    redirect_to(16'd16);
`ifdef FETCH_HALT_EN
    push(16'd16);
    push(16'd18);
    push(16'd20);
    repeat (3) cyc();
    chk("halt_ipc", instr_pc, 16'd20);
    chk("halt_word", instr_out, 16'hFFFF);
    chk("halt_vld", instr_valid, 1);
    chk("halt_flag", halted, 1);
    chk("halt_addr", PCAddress, 16'd22);
    repeat (2) begin
      cyc();
      chk("halted_vld", instr_valid, 0);
      chk("halted_flag", halted, 1);
      chk("halted_addr", PCAddress, 16'd22);
    end
    redirect_to(16'd30);
    run_stream(16'd30, 3);
`else
    run_stream(16'd16, 6);
    chk("nohalt_flag", halted, 0);
`endif

    // Asynchronous reset between edges while a word is presented.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", instr_valid, 0);
    chk("arst_pc", PCAddress, RPC);
    chk("arst_halted", halted, 0);
    chk("arst_ipc", instr_pc, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    run_stream(RPC, 3);

    instr_ready = 1'b0;
    cyc();
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
